// File: rtl/pwm_led_pkg.sv
// Shared types for the PWM LED bank: channel modes and the BREATHE thermometer stepper.
package pwm_led_pkg;

   typedef enum logic [2:0] {
      OFF     = 3'd0,
      ON      = 3'd1,
      FIXED   = 3'd2,
      BREATHE = 3'd3,
      BLINK   = 3'd4
   } mode_e;

   localparam int unsigned MAX_DUTY_BITS = 16;
   localparam logic        DIR_UP        = 1'b0;
   localparam logic        DIR_DOWN      = 1'b1;

   typedef struct packed {
      logic [MAX_DUTY_BITS-1:0] t;
      logic                     dir;
   } therm_t;

   // mask marks the live thermometer width; bits of t above it are always zero.
   function automatic therm_t therm_step(input logic [MAX_DUTY_BITS-1:0] t,
                                         input logic                     dir,
                                         input logic [MAX_DUTY_BITS-1:0] mask);
      therm_t nxt;
      nxt.t   = t;
      nxt.dir = dir;
      if (dir == DIR_UP) begin
         if (t == mask) begin
            nxt.t   = t >> 1;
            nxt.dir = DIR_DOWN;
         end else begin
            nxt.t = {t[MAX_DUTY_BITS-2:0], 1'b1} & mask;
         end
      end else begin
         if (t == '0) begin
            nxt.t   = MAX_DUTY_BITS'(1);
            nxt.dir = DIR_UP;
         end else begin
            nxt.t = t >> 1;
         end
      end
      return nxt;
   endfunction

endpackage

// File: rtl/pwm_led_channel.sv
// One LED channel: mode/level registers, BREATHE and BLINK sequencing, shadowed duty and
// the registered pin driver.
module pwm_led_channel
   import pwm_led_pkg::*;
#(
   parameter int unsigned DUTY_BITS   = 8,
   parameter int unsigned BLINK_STEPS = 4,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DUTY_BITS-1:0] phase,
   input  logic                 wrap,
   input  logic                 step_tick,
   input  logic                 we,
   input  logic [2:0]           mode,
   input  logic [DUTY_BITS-1:0] level,
   output logic                 led
);

   localparam int unsigned          BC_BITS = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;
   localparam logic [BC_BITS-1:0]   BC_LAST = BC_BITS'(BLINK_STEPS - 1);
   localparam logic [DUTY_BITS-1:0] T_FULL  = '1;

   mode_e                mode_q, mode_d;
   logic [DUTY_BITS-1:0] level_q, level_d;
   logic [DUTY_BITS-1:0] t_q, t_d;
   logic                 dir_q, dir_d;
   logic [BC_BITS-1:0]   bcnt_q, bcnt_d;
   logic                 blit_q, blit_d;
   logic [DUTY_BITS-1:0] eff_q, eff_d;
   logic                 led_q, led_d;
   logic [DUTY_BITS-1:0] target;
   logic                 lit;
   therm_t               therm_nxt;

   assign therm_nxt = therm_step(MAX_DUTY_BITS'(t_q), dir_q, MAX_DUTY_BITS'(T_FULL));

   if (DUTY_BITS < MAX_DUTY_BITS) begin : g_therm_hi
      logic unused_therm_hi;
      assign unused_therm_hi = |therm_nxt.t[MAX_DUTY_BITS-1:DUTY_BITS];
   end

   // A write restarts the sequencers and takes priority over a coincident step tick.
   always_comb begin
      mode_d  = mode_q;
      level_d = level_q;
      t_d     = t_q;
      dir_d   = dir_q;
      bcnt_d  = bcnt_q;
      blit_d  = blit_q;
      if (we) begin
         mode_d  = mode_e'(mode);
         level_d = level;
         t_d     = '0;
         dir_d   = DIR_UP;
         bcnt_d  = '0;
         blit_d  = 1'b1;
      end else if (step_tick) begin
         if (mode_q == BREATHE) begin
            t_d   = therm_nxt.t[DUTY_BITS-1:0];
            dir_d = therm_nxt.dir;
         end
         if (mode_q == BLINK) begin
            if (bcnt_q == BC_LAST) begin
               bcnt_d = '0;
               blit_d = ~blit_q;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
      end
   end

   // Codes 5..7 fall through to the default and behave as OFF.
   always_comb begin
      case (mode_q)
         ON:      target = '1;
         FIXED:   target = level_q;
         BREATHE: target = t_q;
         BLINK:   target = blit_q ? level_q : '0;
         default: target = '0;
      endcase
   end

   assign eff_d = wrap ? target : eff_q;
   assign lit   = (mode_q == ON) || (eff_q > phase);
   assign led_d = lit ^ ACTIVE_LOW;
   assign led   = led_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= OFF;
         level_q <= '0;
         t_q     <= '0;
         dir_q   <= DIR_UP;
         bcnt_q  <= '0;
         blit_q  <= 1'b0;
         eff_q   <= '0;
         led_q   <= ACTIVE_LOW;
      end else begin
         mode_q  <= mode_d;
         level_q <= level_d;
         t_q     <= t_d;
         dir_q   <= dir_d;
         bcnt_q  <= bcnt_d;
         blit_q  <= blit_d;
         eff_q   <= eff_d;
         led_q   <= led_d;
      end
   end

endmodule

// File: rtl/pwm_led_bank.sv
// Multi-channel LED brightness engine: shared PWM counter and step prescaler, config
// decode, and one pwm_led_channel per output with staggered PWM phase.
module pwm_led_bank
   import pwm_led_pkg::*;
#(
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned DUTY_BITS   = 8,
   parameter int unsigned STEP_BITS   = 23,
   parameter int unsigned BLINK_STEPS = 4,
   parameter bit          ACTIVE_LOW  = 1'b1,
   localparam int unsigned CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_we,
   input  logic [CH_BITS-1:0]   cfg_ch,
   input  logic [2:0]           cfg_mode,
   input  logic [DUTY_BITS-1:0] cfg_level,
   output logic [CHANNELS-1:0]  led,
   output logic                 step_tick
);

   localparam int unsigned STAGGER = (2 ** DUTY_BITS) / CHANNELS;

   logic [DUTY_BITS-1:0] pwm_cnt_q;
   logic [STEP_BITS-1:0] presc_q;
   logic                 wrap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt_q <= '0;
         presc_q   <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 1'b1;
         presc_q   <= presc_q + 1'b1;
      end
   end

   assign wrap      = (pwm_cnt_q == '1);
   assign step_tick = (presc_q == '1);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [DUTY_BITS-1:0] phase;
      logic                 ch_we;

      // Spreading turn-on points across the period smooths the supply current.
      assign phase = pwm_cnt_q + DUTY_BITS'(i * STAGGER);
      assign ch_we = cfg_we && (cfg_ch == CH_BITS'(i));

      pwm_led_channel #(
         .DUTY_BITS   (DUTY_BITS),
         .BLINK_STEPS (BLINK_STEPS),
         .ACTIVE_LOW  (ACTIVE_LOW)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .phase     (phase),
         .wrap      (wrap),
         .step_tick (step_tick),
         .we        (ch_we),
         .mode      (cfg_mode),
         .level     (cfg_level),
         .led       (led[i])
      );
   end

endmodule
